// File: rtl/lcd_refresh_pkg.sv
// Shared definitions for the HD44780 refresh engine: FSM encodings, LCD command bytes and column helpers.
package lcd_refresh_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned COLS   = 16;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN_HI,
    PH_HOLD,
    PH_WAIT
  } phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ROW1     = 8'h80;
  localparam logic [7:0] CMD_ROW2     = 8'hC0;
  localparam logic [7:0] CHR_SPACE    = 8'h20;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Column 0 sits in the top byte of the line vector.
  function automatic logic [7:0] line_col(input logic [LINE_W-1:0] line, input logic [3:0] col);
    logic [LINE_W-1:0] sh;
    sh = line >> {4'd15 - col, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 byte write: SETUP, EN high, HOLD, then a command-dependent settle wait.
module lcd_byte_tx
  import lcd_refresh_pkg::*;
#(
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int unsigned MAX_WAIT = (T_CLEAR > T_CMD) ? T_CLEAR : T_CMD;
  localparam int unsigned MAX_T    = (MAX_WAIT > T_EN) ? MAX_WAIT : T_EN;
  localparam int unsigned CNT_W    = $clog2(MAX_T + 1);

  phase_t           phase;
  logic [CNT_W-1:0] cnt;
  logic             long_q;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = long_q ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);

  // done is raised during the final WAIT cycle so the caller can chain the next byte without a gap.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      done     <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      done <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (start) begin
            lcd_rs   <= rs;
            lcd_data <= data;
            long_q   <= long_wait;
            cnt      <= '0;
            phase    <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          lcd_en <= 1'b1;
          cnt    <= '0;
          phase  <= PH_EN_HI;
        end
        PH_EN_HI: begin
          if (cnt == CNT_W'(T_EN - 1)) begin
            lcd_en <= 1'b0;
            cnt    <= '0;
            phase  <= PH_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PH_HOLD: begin
          cnt   <= '0;
          done  <= (wait_last == '0);
          phase <= PH_WAIT;
        end
        PH_WAIT: begin
          if (done) begin
            cnt <= '0;
            if (start) begin
              lcd_rs   <= rs;
              lcd_data <= data;
              long_q   <= long_wait;
              phase    <= PH_SETUP;
            end else begin
              phase <= PH_IDLE;
            end
          end else begin
            cnt  <= cnt + CNT_W'(1);
            done <= (CNT_W'(cnt + CNT_W'(1)) == wait_last);
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh.sv
// HD44780 16x2 refresh engine: power-up init, then full two-line rewrites on request.
// Build option LCD_AUTO_REFRESH_EN makes the engine refresh continuously instead of on UPDATE.
module lcd_refresh
  import lcd_refresh_pkg::*;
#(
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLEAR = 82000,
  parameter int unsigned T_INIT  = 750000
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              UPDATE,
  input  logic [LINE_W-1:0] LINE1,
  input  logic [LINE_W-1:0] LINE2,
  output logic              BUSY,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic              LCD_EN,
  output logic [7:0]        LCD_DATA
);

  localparam int unsigned INIT_W = $clog2(T_INIT + 1);

`ifdef LCD_AUTO_REFRESH_EN
  localparam logic AUTO_REFRESH = 1'b1;
`else
  localparam logic AUTO_REFRESH = 1'b0;
`endif

  state_t            state;
  logic [INIT_W-1:0] pwr_cnt;
  logic [3:0]        idx;
  logic              pending;
  logic [LINE_W-1:0] snap1;
  logic [LINE_W-1:0] snap2;

  logic              tx_done;
  logic              start_c;
  logic              tx_rs_c;
  logic [7:0]        tx_data_c;
  logic              tx_long_c;
  logic              refresh_c;
  logic              want_c;

  assign want_c = AUTO_REFRESH | UPDATE | pending;
  assign LCD_RW = 1'b0;

  // Selects the byte to launch this cycle; a refresh (re)start also snapshots the lines.
  always_comb begin
    start_c   = 1'b0;
    tx_rs_c   = 1'b0;
    tx_data_c = 8'h00;
    refresh_c = 1'b0;
    case (state)
      ST_PWR_WAIT: begin
        if (pwr_cnt == INIT_W'(T_INIT - 1)) begin
          start_c   = 1'b1;
          tx_data_c = CMD_FUNC_SET;
        end
      end
      ST_INIT: begin
        if (tx_done) begin
          if (idx != 4'd3) begin
            start_c   = 1'b1;
            tx_data_c = init_cmd(idx[1:0] + 2'd1);
          end else if (want_c) begin
            start_c   = 1'b1;
            tx_data_c = CMD_ROW1;
            refresh_c = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (want_c) begin
          start_c   = 1'b1;
          tx_data_c = CMD_ROW1;
          refresh_c = 1'b1;
        end
      end
      ST_ADDR1: begin
        if (tx_done) begin
          start_c   = 1'b1;
          tx_rs_c   = 1'b1;
          tx_data_c = line_col(snap1, 4'd0);
        end
      end
      ST_LINE1: begin
        if (tx_done) begin
          start_c = 1'b1;
          if (idx != 4'd15) begin
            tx_rs_c   = 1'b1;
            tx_data_c = line_col(snap1, idx + 4'd1);
          end else begin
            tx_data_c = CMD_ROW2;
          end
        end
      end
      ST_ADDR2: begin
        if (tx_done) begin
          start_c   = 1'b1;
          tx_rs_c   = 1'b1;
          tx_data_c = line_col(snap2, 4'd0);
        end
      end
      ST_LINE2: begin
        if (tx_done) begin
          if (idx != 4'd15) begin
            start_c   = 1'b1;
            tx_rs_c   = 1'b1;
            tx_data_c = line_col(snap2, idx + 4'd1);
          end else if (want_c) begin
            start_c   = 1'b1;
            tx_data_c = CMD_ROW1;
            refresh_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
    tx_long_c = (tx_data_c == CMD_CLEAR) && !tx_rs_c;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= ST_PWR_WAIT;
      pwr_cnt <= '0;
      idx     <= '0;
      pending <= 1'b0;
      snap1   <= {COLS{CHR_SPACE}};
      snap2   <= {COLS{CHR_SPACE}};
      BUSY    <= 1'b1;
    end else begin
      if (refresh_c) begin
        snap1   <= LINE1;
        snap2   <= LINE2;
        pending <= 1'b0;
      end else if (UPDATE) begin
        pending <= 1'b1;
      end
      case (state)
        ST_PWR_WAIT: begin
          if (start_c) begin
            state <= ST_INIT;
            idx   <= '0;
          end else begin
            pwr_cnt <= pwr_cnt + INIT_W'(1);
          end
        end
        ST_INIT: begin
          if (tx_done) begin
            if (idx != 4'd3) begin
              idx <= idx + 4'd1;
            end else if (refresh_c) begin
              state <= ST_ADDR1;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        ST_IDLE: begin
          if (refresh_c) begin
            state <= ST_ADDR1;
            BUSY  <= 1'b1;
          end
        end
        ST_ADDR1: begin
          if (tx_done) begin
            state <= ST_LINE1;
            idx   <= '0;
          end
        end
        ST_LINE1: begin
          if (tx_done) begin
            if (idx != 4'd15) idx <= idx + 4'd1;
            else              state <= ST_ADDR2;
          end
        end
        ST_ADDR2: begin
          if (tx_done) begin
            state <= ST_LINE2;
            idx   <= '0;
          end
        end
        ST_LINE2: begin
          if (tx_done) begin
            if (idx != 4'd15) begin
              idx <= idx + 4'd1;
            end else if (refresh_c) begin
              state <= ST_ADDR1;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: state <= ST_PWR_WAIT;
      endcase
    end
  end

  lcd_byte_tx #(
    .T_EN    (T_EN),
    .T_CMD   (T_CMD),
    .T_CLEAR (T_CLEAR)
  ) u_tx (
    .CLK       (CLK),
    .CLR       (CLR),
    .start     (start_c),
    .rs        (tx_rs_c),
    .data      (tx_data_c),
    .long_wait (tx_long_c),
    .done      (tx_done),
    .lcd_en    (LCD_EN),
    .lcd_rs    (LCD_RS),
    .lcd_data  (LCD_DATA)
  );

endmodule

// File: tb/tb_lcd_refresh.sv
// Directed bench for lcd_refresh with short timing parameters; bytes and timing checked against hand-derived values.
module tb_lcd_refresh;

  localparam int unsigned T_EN    = 2;
  localparam int unsigned T_CMD   = 4;
  localparam int unsigned T_CLEAR = 8;
  localparam int unsigned T_INIT  = 20;
  localparam int XFER    = 8;
  localparam int REFRESH = 272;

  logic         CLK = 1'b0;
  logic         CLR = 1'b0;
  logic         UPDATE = 1'b0;
  logic [127:0] LINE1;
  logic [127:0] LINE2;
  logic         BUSY;
  logic         LCD_RS;
  logic         LCD_RW;
  logic         LCD_EN;
  logic [7:0]   LCD_DATA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  lcd_refresh #(
    .T_EN    (T_EN),
    .T_CMD   (T_CMD),
    .T_CLEAR (T_CLEAR),
    .T_INIT  (T_INIT)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .UPDATE   (UPDATE),
    .LINE1    (LINE1),
    .LINE2    (LINE2),
    .BUSY     (BUSY),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_DATA (LCD_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  // Waits for the next EN strobe, returns its byte and the cycle it rose, and checks its width.
  task automatic get_byte(output logic rs, output logic [7:0] data, output int rise);
    int n;
    n = 0;
    rs = 1'b0;
    data = 8'h00;
    rise = -1;
    do begin
      @(negedge CLK);
      n++;
    end while (LCD_EN !== 1'b1 && n < 100);
    if (LCD_EN !== 1'b1) begin
      chk("en_timeout", 32'(LCD_EN), 32'd1);
      return;
    end
    rise = cyc;
    rs   = LCD_RS;
    data = LCD_DATA;
    n = 0;
    while (LCD_EN === 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("en_width", 32'(n), 32'(T_EN));
  endtask

  function automatic logic [8:0] exp_byte(input logic [127:0] l1, input logic [127:0] l2, input int i);
    if (i == 0)       return {1'b0, 8'h80};
    else if (i <= 16) return {1'b1, l1[127-8*(i-1) -: 8]};
    else if (i == 17) return {1'b0, 8'hC0};
    else              return {1'b1, l2[127-8*(i-18) -: 8]};
  endfunction

  task automatic check_init(input int c0);
    logic       rs;
    logic [7:0] d;
    int         rise;
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      get_byte(rs, d, rise);
      chk($sformatf("init%0d_data", i), 32'(d), 32'(cmds[i]));
      chk($sformatf("init%0d_rs", i), 32'(rs), 32'd0);
      chk($sformatf("init%0d_rise", i), 32'(rise), 32'(c0 + 21 + XFER * i));
    end
  endtask

  // Caller is at the negedge of the ADDR1 SETUP cycle s; poke>=0 disturbs inputs after that byte.
  task automatic do_refresh(input logic [127:0] l1, input logic [127:0] l2, input int s, input int poke);
    logic       rs;
    logic [7:0] d;
    int         rise;
    chk("setup_busy", 32'(BUSY), 32'd1);
    chk("setup_data", 32'(LCD_DATA), 32'h80);
    chk("setup_rs", 32'(LCD_RS), 32'd0);
    chk("setup_en", 32'(LCD_EN), 32'd0);
    for (int i = 0; i < 34; i++) begin
      get_byte(rs, d, rise);
      chk($sformatf("byte%0d", i), 32'({rs, d}), 32'(exp_byte(l1, l2, i)));
      chk($sformatf("rise%0d", i), 32'(rise), 32'(s + 1 + XFER * i));
      if (i == poke) begin
        LINE1 = {16{8'h41}};
        UPDATE = 1'b1;
        @(negedge CLK) UPDATE = 1'b0;
        @(negedge CLK) UPDATE = 1'b1;
        @(negedge CLK) UPDATE = 1'b0;
      end
    end
  endtask

  initial begin
    int c0;
    int s;
    int n;
    int lows;
    logic [127:0] l1o;
    logic       rs;
    logic [7:0] d;
    int         rise;

    LINE1 = {16{8'h20}};
    LINE2 = {16{8'h20}};
    repeat (3) @(negedge CLK);
    chk("rst_en", 32'(LCD_EN), 32'd0);
    chk("rst_rs", 32'(LCD_RS), 32'd0);
    chk("rst_rw", 32'(LCD_RW), 32'd0);
    chk("rst_data", 32'(LCD_DATA), 32'h00);
    chk("rst_busy", 32'(BUSY), 32'd1);

    CLR = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 10);
    chk("pwr_en", 32'(LCD_EN), 32'd0);
    check_init(c0);
    wait_cyc(c0 + 55);
    chk("clear_wait_busy", 32'(BUSY), 32'd1);
    wait_cyc(c0 + 56);

`ifdef LCD_AUTO_REFRESH_EN
    do_refresh(LINE1, LINE2, c0 + 56, -1);
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (BUSY !== 1'b1) lows++;
    end
    chk("auto_busy_low", 32'(lows), 32'd0);
`else
    chk("idle_busy", 32'(BUSY), 32'd0);
    wait_cyc(c0 + 70);
    chk("idle_stays", 32'(BUSY), 32'd0);

    // Plain refresh: "UFCG" then spaces.
    LINE1 = {32'h55464347, {12{8'h20}}};
    UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    s = cyc;
    do_refresh(LINE1, LINE2, s, -1);
    wait_cyc(s + REFRESH - 1);
    chk("last_wait_busy", 32'(BUSY), 32'd1);
    wait_cyc(s + REFRESH);
    chk("busy_fall", 32'(BUSY), 32'd0);

    // Input change plus two merged requests during a refresh.
    wait_cyc(s + REFRESH + 5);
    LINE1 = "0123456789ABCDEF";
    LINE2 = "abcdefghijklmnop";
    l1o = LINE1;
    UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    s = cyc;
    do_refresh(l1o, LINE2, s, 4);
    wait_cyc(s + REFRESH);
    do_refresh({16{8'h41}}, LINE2, s + REFRESH, -1);
    wait_cyc(s + 2 * REFRESH);
    chk("pending_once_busy", 32'(BUSY), 32'd0);
    wait_cyc(s + 2 * REFRESH + 20);
    chk("no_third_busy", 32'(BUSY), 32'd0);
    chk("no_third_en", 32'(LCD_EN), 32'd0);

    // Reset during EN high of the tenth byte.
    LINE1 = l1o;
    UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    for (int i = 0; i < 9; i++) get_byte(rs, d, rise);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (LCD_EN !== 1'b1 && n < 20);
    chk("byte10_en_seen", 32'(LCD_EN), 32'd1);
    #2 CLR = 1'b0;
    #1;
    chk("async_en", 32'(LCD_EN), 32'd0);
    chk("async_data", 32'(LCD_DATA), 32'h00);
    chk("async_busy", 32'(BUSY), 32'd1);
    repeat (2) @(negedge CLK);

    // Request during power-up wait is serviced right after init.
    LINE1 = "PENDING UPDATE!!";
    CLR = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 5);
    UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    wait_cyc(c0 + 10);
    chk("rerun_pwr_en", 32'(LCD_EN), 32'd0);
    chk("rerun_pwr_busy", 32'(BUSY), 32'd1);
    check_init(c0);
    wait_cyc(c0 + 56);
    do_refresh(LINE1, LINE2, c0 + 56, -1);
    wait_cyc(c0 + 56 + REFRESH);
    chk("post_pending_busy", 32'(BUSY), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
